// File: rtl/oram_arbiter_pkg.sv
// Shared sizes and state encoding for the ORAM front-end arbiter.
package oramPkg;

   localparam int a                = 2;
   localparam int d                = 4;
   localparam int ORAM_NREQ        = 4;
   localparam int ORAM_TIMEOUT_CYC = 255;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } arb_state_t;

endpackage

// File: rtl/oram_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request after index `last`, with wrap.
module oram_rr_picker #(
   parameter int NREQ = 4,
   parameter int IW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   idx,
   output logic            any
);

   int dist_s;
   int best_s;

   // Distance 1 is the slot right after `last`; `last` itself is the farthest (NREQ).
   always_comb begin
      grant  = '0;
      idx    = '0;
      any    = 1'b0;
      dist_s = 0;
      best_s = NREQ + 1;
      for (int j = 0; j < NREQ; j++) begin
         if (j > int'(last)) begin
            dist_s = j - int'(last);
         end else begin
            dist_s = j - int'(last) + NREQ;
         end
         if (req[j] && (dist_s < best_s)) begin
            best_s   = dist_s;
            grant    = '0;
            grant[j] = 1'b1;
            idx      = IW'(j);
            any      = 1'b1;
         end else begin
            best_s = best_s;
         end
      end
   end

endmodule

// File: rtl/oram_arbiter.sv
// Round-robin arbiter that shares one oram_module among NREQ requesters.
// Define ORAM_ARB_TIMEOUT_EN to add a BUSY watchdog that answers with rsp_err.
module oram_arbiter
   import oramPkg::*;
#(
   parameter int NREQ        = ORAM_NREQ,
   parameter int TIMEOUT_CYC = ORAM_TIMEOUT_CYC
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [NREQ-1:0]     req_rw,
   input  logic [NREQ*d-1:0]   req_block,
   input  logic [NREQ*8*a-1:0] req_wdata,
   output logic [NREQ-1:0]     req_grant,
   output logic [NREQ-1:0]     rsp_valid,
   output logic [8*a-1:0]      rsp_rdata,
   output logic                rsp_err,
   output logic [d-1:0]        oram_block,
   output logic [8*a-1:0]      oram_wdata,
   output logic                oram_rw,
   output logic                oram_input_ready,
   input  logic [8*a-1:0]      oram_read_val,
   input  logic                oram_output_ready
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int DW = 8 * a;

   arb_state_t      state_q, state_d;
   logic [IW-1:0]   last_q, last_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
   logic            rw_q, rw_d;
   logic [d-1:0]    block_q, block_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            in_rdy_q, in_rdy_d;
   logic            err_q, err_d;

   logic [NREQ-1:0] pick_grant_s;
   logic [IW-1:0]   pick_idx_s;
   logic            pick_any_s;
   logic            sel_rw_s;
   logic [d-1:0]    sel_block_s;
   logic [DW-1:0]   sel_wdata_s;

`ifdef ORAM_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0] cnt_q, cnt_d;
`else
   localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

   oram_rr_picker #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_picker (
      .req   (req_valid),
      .last  (last_q),
      .grant (pick_grant_s),
      .idx   (pick_idx_s),
      .any   (pick_any_s)
   );

   // Fields of the requester the picker chose, latched together with the grant.
   always_comb begin
      sel_rw_s    = 1'b0;
      sel_block_s = '0;
      sel_wdata_s = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (pick_grant_s[j]) begin
            sel_rw_s    = req_rw[j];
            sel_block_s = req_block[j*d +: d];
            sel_wdata_s = req_wdata[j*DW +: DW];
         end else begin
            sel_rw_s = sel_rw_s;
         end
      end
   end

   // Next-state logic; IDLE spends the grant-pulse cycle before moving to BUSY.
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      idx_d       = idx_q;
      grant_d     = '0;
      rsp_valid_d = '0;
      rw_d        = rw_q;
      block_d     = block_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      in_rdy_d    = in_rdy_q;
      err_d       = err_q;
`ifdef ORAM_ARB_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (grant_q != '0) begin
               state_d  = ST_BUSY;
               in_rdy_d = 1'b1;
`ifdef ORAM_ARB_TIMEOUT_EN
               cnt_d    = '0;
`endif
            end else if (pick_any_s) begin
               grant_d = pick_grant_s;
               idx_d   = pick_idx_s;
               last_d  = pick_idx_s;
               rw_d    = sel_rw_s;
               block_d = sel_block_s;
               wdata_d = sel_wdata_s;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (oram_output_ready) begin
               state_d            = ST_RESP;
               in_rdy_d           = 1'b0;
               rsp_valid_d[idx_q] = 1'b1;
               rdata_d            = rw_q ? '0 : oram_read_val;
               err_d              = 1'b0;
`ifdef ORAM_ARB_TIMEOUT_EN
            end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
               state_d            = ST_RESP;
               in_rdy_d           = 1'b0;
               rsp_valid_d[idx_q] = 1'b1;
               rdata_d            = '0;
               err_d              = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
`else
            end else begin
               state_d = ST_BUSY;
            end
`endif
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d  = ST_IDLE;
            in_rdy_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers; rst clears everything, even mid-transaction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         last_q      <= IW'(NREQ - 1);
         idx_q       <= '0;
         grant_q     <= '0;
         rsp_valid_q <= '0;
         rw_q        <= 1'b0;
         block_q     <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         in_rdy_q    <= 1'b0;
         err_q       <= 1'b0;
`ifdef ORAM_ARB_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         idx_q       <= idx_d;
         grant_q     <= grant_d;
         rsp_valid_q <= rsp_valid_d;
         rw_q        <= rw_d;
         block_q     <= block_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         in_rdy_q    <= in_rdy_d;
         err_q       <= err_d;
`ifdef ORAM_ARB_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign req_grant        = grant_q;
   assign rsp_valid        = rsp_valid_q;
   assign rsp_rdata        = rdata_q;
   assign rsp_err          = err_q;
   assign oram_block       = block_q;
   assign oram_wdata       = wdata_q;
   assign oram_rw          = rw_q;
   assign oram_input_ready = in_rdy_q;

endmodule

// File: tb/tb_oram_arbiter.sv
// Self-checking bench for oram_arbiter: transaction-level model plus bench-side ORAM memory.
module tb_oram_arbiter;
   import oramPkg::*;

   localparam int NR = ORAM_NREQ;
   localparam int DW = 8 * a;
   localparam int BW = d;
   localparam int TO = ORAM_TIMEOUT_CYC;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NR-1:0]   req_valid, req_rw, req_grant, rsp_valid;
   logic [NR*BW-1:0] req_block;
   logic [NR*DW-1:0] req_wdata;
   logic [DW-1:0]   rsp_rdata, oram_wdata, oram_read_val;
   logic            rsp_err, oram_rw, oram_input_ready, oram_output_ready;
   logic [BW-1:0]   oram_block;

   oram_arbiter dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_rw(req_rw),
      .req_block(req_block), .req_wdata(req_wdata), .req_grant(req_grant),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .oram_block(oram_block), .oram_wdata(oram_wdata), .oram_rw(oram_rw),
      .oram_input_ready(oram_input_ready), .oram_read_val(oram_read_val),
      .oram_output_ready(oram_output_ready)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   // transaction-level model
   int            m_last;
   bit            m_busy, m_arb, m_rsp_due, m_rw, m_err;
   int            m_idx, m_blk, m_tcnt;
   logic [DW-1:0] m_wd, m_rdata;
   logic [DW-1:0] mem [0:(1<<BW)-1];
   logic [NR-1:0] p_valid, p_rw;
   logic [NR*BW-1:0] p_block;
   logic [NR*DW-1:0] p_wdata;

   bit auto_req, hold_all, noise;
   int or_mode;
   int cyc = 0;
   int ir_rise_cyc = -100;
   bit prev_ir = 1'b0;
   int glog[$], glog_cyc[$], rlog_v[$], rlog_d[$], rlog_e[$];
   int n0, g0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic sync_prev();
      p_valid = req_valid;
      p_rw    = req_rw;
      p_block = req_block;
      p_wdata = req_wdata;
   endtask

   task automatic set_req(input int i, input logic rw, input int blk, input int wd);
      req_valid[i]            = 1'b1;
      req_rw[i]               = rw;
      req_block[i*BW +: BW]   = BW'(blk);
      req_wdata[i*DW +: DW]   = DW'(wd);
      sync_prev();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      oram_output_ready = 1'b0;
      @(negedge clk);
      chk("rst_grant", 32'(req_grant), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_input_ready", 32'(oram_input_ready), 32'd0);
      chk("rst_rdata", 32'(rsp_rdata), 32'd0);
      chk("rst_err", 32'(rsp_err), 32'd0);
      chk("rst_oram_fields", {oram_rw, 11'd0, oram_block, oram_wdata}, 32'd0);
      rst       = 1'b0;
      m_busy    = 1'b0;
      m_rsp_due = 1'b0;
      m_arb     = 1'b1;
      m_last    = NR - 1;
      m_tcnt    = 0;
      prev_ir   = 1'b0;
      sync_prev();
   endtask

   // One clock: check outputs against the model, then act as ORAM and requesters.
   task automatic cycle();
      int            pick;
      logic [NR-1:0] eg, er;
      bit            ir_e, r_now, fire;
      @(negedge clk);
      cyc++;
      pick = -1;
      eg   = '0;
      if (m_arb && p_valid != '0) begin
         for (int k = 1; k <= NR; k++) begin
            int c;
            c = (m_last + k) % NR;
            if (pick < 0 && p_valid[c]) pick = c;
         end
         eg[pick] = 1'b1;
      end
      chk("grant", 32'(req_grant), 32'(eg));
      if (req_grant != '0) begin
         glog.push_back(int'(req_grant));
         glog_cyc.push_back(cyc);
      end
      r_now = m_rsp_due;
      er    = '0;
      if (r_now) er[m_idx] = 1'b1;
      chk("rsp_valid", 32'(rsp_valid), 32'(er));
      if (r_now) begin
         chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
         chk("rsp_err", 32'(rsp_err), 32'(m_err));
      end
      if (rsp_valid != '0) begin
         rlog_v.push_back(int'(rsp_valid));
         rlog_d.push_back(int'(rsp_rdata));
         rlog_e.push_back(int'(rsp_err));
      end
      if (pick >= 0) begin
         m_busy = 1'b1;
         m_idx  = pick;
         m_last = pick;
         m_rw   = p_rw[pick];
         m_blk  = int'(p_block[pick*BW +: BW]);
         m_wd   = p_wdata[pick*DW +: DW];
         m_tcnt = 0;
      end
      ir_e = m_busy && (pick < 0) && !r_now;
      chk("input_ready", 32'(oram_input_ready), 32'(ir_e));
      if (ir_e) begin
         chk("oram_rw", 32'(oram_rw), 32'(m_rw));
         chk("oram_block", 32'(oram_block), 32'(m_blk));
         chk("oram_wdata", 32'(oram_wdata), 32'(m_wd));
      end
      if (oram_input_ready && !prev_ir) ir_rise_cyc = cyc;
      prev_ir = oram_input_ready;
      m_arb = !m_busy;
      if (r_now) begin
         m_busy    = 1'b0;
         m_rsp_due = 1'b0;
      end

      oram_output_ready = 1'b0;
      oram_read_val     = DW'($urandom);
      if (ir_e) begin
         fire = (or_mode == 1) && ($urandom_range(0, 2) == 0);
         if (fire) begin
            oram_output_ready = 1'b1;
            if (m_rw) begin
               mem[m_blk] = m_wd;
               m_rdata    = '0;
            end else begin
               oram_read_val = mem[m_blk];
               m_rdata       = mem[m_blk];
            end
            m_err     = 1'b0;
            m_rsp_due = 1'b1;
         end else begin
`ifdef ORAM_ARB_TIMEOUT_EN
            m_tcnt++;
            if (m_tcnt == TO) begin
               m_rsp_due = 1'b1;
               m_rdata   = '0;
               m_err     = 1'b1;
            end
`endif
         end
      end else if (noise && $urandom_range(0, 3) == 0) begin
         oram_output_ready = 1'b1;
      end

      for (int i = 0; i < NR; i++) begin
         if (req_grant[i] && !hold_all) begin
            if (!(auto_req && $urandom_range(0, 3) == 0)) req_valid[i] = 1'b0;
            req_rw[i]             = 1'($urandom_range(0, 1));
            req_block[i*BW +: BW] = BW'($urandom);
            req_wdata[i*DW +: DW] = DW'($urandom);
         end else if (auto_req && !req_valid[i] && $urandom_range(0, 4) == 0) begin
            req_valid[i]          = 1'b1;
            req_rw[i]             = 1'($urandom_range(0, 1));
            req_block[i*BW +: BW] = BW'($urandom);
            req_wdata[i*DW +: DW] = DW'($urandom);
         end
      end
      sync_prev();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      req_valid = '0; req_rw = '0; req_block = '0; req_wdata = '0;
      oram_read_val = '0; oram_output_ready = 1'b0;
      auto_req = 1'b0; hold_all = 1'b0; noise = 1'b0; or_mode = 1;
      for (int i = 0; i < (1 << BW); i++) mem[i] = '0;
      do_reset();

      // requester 1 writes 2 to block 1
      n0 = rlog_v.size();
      ir_rise_cyc = -100;
      set_req(1, 1'b1, 1, 2);
      run(40);
      chk("wr_grant", (glog.size() > 0) ? glog[glog.size()-1] : -1, 32'h2);
      chk("wr_ir_latency", (glog_cyc.size() > 0) ? ir_rise_cyc - glog_cyc[glog_cyc.size()-1] : -1, 32'd1);
      chk("wr_rsp_count", rlog_v.size() - n0, 32'd1);
      chk("wr_rsp_valid", (rlog_v.size() > 0) ? rlog_v[rlog_v.size()-1] : -1, 32'h2);
      chk("wr_rsp_err", (rlog_e.size() > 0) ? rlog_e[rlog_e.size()-1] : -1, 32'h0);

      // requester 1 reads block 1 back
      set_req(1, 1'b0, 1, 0);
      run(40);
      chk("rd_rsp_valid", (rlog_v.size() > 0) ? rlog_v[rlog_v.size()-1] : -1, 32'h2);
      chk("rd_rsp_rdata", (rlog_d.size() > 0) ? rlog_d[rlog_d.size()-1] : -1, 32'h2);

      // all four held from reset: strict rotation
      req_valid = '1;
      req_rw = '0;
      hold_all = 1'b1;
      do_reset();
      glog.delete();
      glog_cyc.delete();
      for (int t = 0; t < 300 && glog.size() < 5; t++) cycle();
      chk("rr_count", (glog.size() >= 5) ? 32'd5 : 32'(glog.size()), 32'd5);
      chk("rr_g0", (glog.size() > 0) ? glog[0] : -1, 32'h1);
      chk("rr_g1", (glog.size() > 1) ? glog[1] : -1, 32'h2);
      chk("rr_g2", (glog.size() > 2) ? glog[2] : -1, 32'h4);
      chk("rr_g3", (glog.size() > 3) ? glog[3] : -1, 32'h8);
      chk("rr_g4", (glog.size() > 4) ? glog[4] : -1, 32'h1);
      hold_all = 1'b0;
      req_valid = '0;
      sync_prev();
      run(40);

      // output_ready pulses while idle are ignored
      n0 = rlog_v.size();
      g0 = glog.size();
      noise = 1'b1;
      run(20);
      noise = 1'b0;
      chk("idle_or_rsp", rlog_v.size() - n0, 32'd0);
      chk("idle_or_grant", glog.size() - g0, 32'd0);

      // reset while BUSY, then normal service
      or_mode = 0;
      set_req(2, 1'b0, 3, 0);
      for (int t = 0; t < 20 && !oram_input_ready; t++) cycle();
      chk("busy_before_rst", 32'(oram_input_ready), 32'd1);
      run(3);
      req_valid = '0;
      do_reset();
      run(5);
      or_mode = 1;
      n0 = rlog_v.size();
      set_req(0, 1'b1, 5, 'h1234);
      run(40);
      set_req(3, 1'b0, 5, 0);
      run(40);
      chk("post_rst_count", rlog_v.size() - n0, 32'd2);
      chk("post_rst_wr", (rlog_v.size() > 1) ? rlog_v[rlog_v.size()-2] : -1, 32'h1);
      chk("post_rst_rd", (rlog_d.size() > 0) ? rlog_d[rlog_d.size()-1] : -1, 32'h1234);

      // randomized traffic with idle noise and mid-transaction input changes
      g0 = glog.size();
      auto_req = 1'b1;
      noise = 1'b1;
      run(1500);
      auto_req = 1'b0;
      noise = 1'b0;
      req_valid = '0;
      sync_prev();
      run(60);
      chk("rand_activity", 32'(glog.size() - g0 > 50), 32'd1);

      // oram never answers
      or_mode = 0;
      n0 = rlog_v.size();
      set_req(3, 1'b0, 2, 0);
      run(TO + 20);
`ifdef ORAM_ARB_TIMEOUT_EN
      chk("to_count", rlog_v.size() - n0, 32'd1);
      chk("to_valid", (rlog_v.size() > 0) ? rlog_v[rlog_v.size()-1] : -1, 32'h8);
      chk("to_err", (rlog_e.size() > 0) ? rlog_e[rlog_e.size()-1] : -1, 32'h1);
      chk("to_rdata", (rlog_d.size() > 0) ? rlog_d[rlog_d.size()-1] : -1, 32'h0);
`else
      chk("stuck_no_rsp", rlog_v.size() - n0, 32'd0);
      chk("stuck_still_busy", 32'(oram_input_ready), 32'd1);
`endif
      do_reset();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
